// File: rtl/bit_scan_64b.sv
// Sequential set-bit enumerator: walks a request mask lowest bit first and
// emits one index (binary and one-hot) per accepted output beat.
module bit_scan_64b #(
  parameter  int DATA_WIDTH = 64,
  localparam int IDX_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  abort_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [IDX_WIDTH-1:0]  out_idx_o,
  output logic [DATA_WIDTH-1:0] out_onehot_o,
  output logic                  out_last_o,
  output logic                  done_o,
  output logic [IDX_WIDTH:0]    cnt_o
);

  localparam int NUM_GROUPS = DATA_WIDTH / 8;
  localparam int GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mask_r;
  logic [DATA_WIDTH-1:0] lowest;
  logic [IDX_WIDTH:0]    cnt_r;
  logic                  done_r;
  logic                  in_scan;
  logic                  handshake;

  logic [NUM_GROUPS-1:0] grp_any;
  logic [NUM_GROUPS-1:0] grp_onehot;
  logic [GRP_W-1:0]      grp_idx;
  logic [7:0]            sel_byte;
  logic [7:0]            byte_onehot;
  logic [2:0]            bit_idx;
  logic [GRP_W+2:0]      idx_full;

  assign in_scan   = (state_q == SCAN);
  assign lowest    = mask_r & (~mask_r + DATA_WIDTH'(1));
  assign handshake = in_scan & out_ready_i;

  // Two-level encoder: pick the lowest non-empty byte, then the lowest bit
  // inside it, so the index never depends on a full-width priority chain.
  always_comb begin
    grp_any  = '0;
    grp_idx  = '0;
    sel_byte = '0;
    bit_idx  = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      grp_any[g] = |mask_r[g*8 +: 8];
    end
    grp_onehot = grp_any & (~grp_any + NUM_GROUPS'(1));
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (grp_onehot[g]) begin
        grp_idx  = grp_idx | GRP_W'(g);
        sel_byte = sel_byte | mask_r[g*8 +: 8];
      end
    end
    byte_onehot = sel_byte & (~sel_byte + 8'd1);
    for (int b = 0; b < 8; b++) begin
      if (byte_onehot[b]) begin
        bit_idx = bit_idx | 3'(b);
      end
    end
    idx_full = {grp_idx, bit_idx};
  end

  assign in_ready_o   = ~in_scan;
  assign out_valid_o  = in_scan;
  assign out_idx_o    = in_scan ? idx_full[IDX_WIDTH-1:0] : '0;
  assign out_onehot_o = in_scan ? lowest : '0;
  assign out_last_o   = in_scan && ((mask_r & ~lowest) == '0);
  assign done_o       = done_r;
  assign cnt_o        = cnt_r;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i && !abort_i && (data_i != '0)) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (abort_i || (handshake && out_last_o)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort beats a simultaneous handshake: that beat is dropped, not counted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask_r <= '0;
      cnt_r  <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (!in_scan) begin
        if (in_valid_i && !abort_i) begin
          mask_r <= data_i;
          cnt_r  <= '0;
          if (data_i == '0) begin
            done_r <= 1'b1;
          end
        end
      end else if (abort_i) begin
        mask_r <= '0;
      end else if (handshake) begin
        mask_r <= mask_r & ~lowest;
        cnt_r  <= cnt_r + 1'b1;
        if (out_last_o) begin
          done_r <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_scan_64b.sv
// Directed bench for bit_scan_64b: a per-cycle vector table plus hand-written
// sequences for the full mask, abort and mid-scan reset cases.
module tb_bit_scan_64b;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [63:0] data_i;
  logic        abort_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [5:0]  out_idx_o;
  logic [63:0] out_onehot_o;
  logic        out_last_o;
  logic        done_o;
  logic [6:0]  cnt_o;

  int total_checks  = 0;
  int passed_checks = 0;

  always #5 clk_i = ~clk_i;

  bit_scan_64b dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .data_i       (data_i),
    .abort_i      (abort_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_idx_o    (out_idx_o),
    .out_onehot_o (out_onehot_o),
    .out_last_o   (out_last_o),
    .done_o       (done_o),
    .cnt_o        (cnt_o)
  );

  typedef struct {
    logic        in_valid;
    logic [63:0] data;
    logic        abort;
    logic        out_ready;
    logic        exp_in_ready;
    logic        exp_valid;
    logic [5:0]  exp_idx;
    logic [63:0] exp_onehot;
    logic        exp_last;
    logic        exp_done;
    logic [6:0]  exp_cnt;
  } vec_t;

  task automatic applyStimulus(input logic iv, input logic [63:0] d,
                               input logic ab, input logic ordy);
    @(negedge clk_i);
    in_valid_i  = iv;
    data_i      = d;
    abort_i     = ab;
    out_ready_i = ordy;
    #1;
  endtask

  task automatic checkField(input string name, input logic [63:0] act,
                            input logic [63:0] exp);
    total_checks++;
    if (act === exp) begin
      passed_checks++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic e_rdy,
                             input logic e_val, input logic [5:0] e_idx,
                             input logic [63:0] e_oh, input logic e_last,
                             input logic e_done, input logic [6:0] e_cnt);
    checkField({name, ".in_ready"}, 64'(in_ready_o), 64'(e_rdy));
    checkField({name, ".out_valid"}, 64'(out_valid_o), 64'(e_val));
    checkField({name, ".out_idx"}, 64'(out_idx_o), 64'(e_idx));
    checkField({name, ".out_onehot"}, out_onehot_o, e_oh);
    checkField({name, ".out_last"}, 64'(out_last_o), 64'(e_last));
    checkField({name, ".done"}, 64'(done_o), 64'(e_done));
    checkField({name, ".cnt"}, 64'(cnt_o), 64'(e_cnt));
  endtask

  vec_t vecs[17];

  initial begin
    // Outputs seen in a row reflect state from the previous edge; inputs
    // in a row take effect at the following edge.
    vecs[0]  = '{1, 64'h91, 0, 1, 1, 0, 0,  64'h0, 0, 0, 0};
    vecs[1]  = '{0, 64'h0,  0, 1, 0, 1, 0,  64'h1, 0, 0, 0};
    vecs[2]  = '{0, 64'h0,  0, 1, 0, 1, 4,  64'h10, 0, 0, 1};
    vecs[3]  = '{0, 64'h0,  0, 1, 0, 1, 7,  64'h80, 1, 0, 2};
    vecs[4]  = '{0, 64'h0,  0, 1, 1, 0, 0,  64'h0, 0, 1, 3};
    vecs[5]  = '{0, 64'h0,  0, 1, 1, 0, 0,  64'h0, 0, 0, 3};
    vecs[6]  = '{1, 64'h0,  0, 1, 1, 0, 0,  64'h0, 0, 0, 3};
    vecs[7]  = '{0, 64'h0,  0, 1, 1, 0, 0,  64'h0, 0, 1, 0};
    vecs[8]  = '{0, 64'h0,  0, 1, 1, 0, 0,  64'h0, 0, 0, 0};
    vecs[9]  = '{1, 64'h8000_0001_0000_0000, 0, 1, 1, 0, 0, 64'h0, 0, 0, 0};
    vecs[10] = '{0, 64'h0,  0, 1, 0, 1, 32, 64'h1_0000_0000, 0, 0, 0};
    vecs[11] = '{0, 64'h0,  0, 0, 0, 1, 63, 64'h8000_0000_0000_0000, 1, 0, 1};
    vecs[12] = '{0, 64'h0,  0, 0, 0, 1, 63, 64'h8000_0000_0000_0000, 1, 0, 1};
    vecs[13] = '{0, 64'h0,  0, 1, 0, 1, 63, 64'h8000_0000_0000_0000, 1, 0, 1};
    vecs[14] = '{1, 64'h100, 0, 1, 1, 0, 0, 64'h0, 0, 1, 2};
    vecs[15] = '{0, 64'h0,  0, 1, 0, 1, 8,  64'h100, 1, 0, 0};
    vecs[16] = '{0, 64'h0,  0, 1, 1, 0, 0,  64'h0, 0, 1, 1};

    rst_i = 1'b1;
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
    checkOutput("reset", 1, 0, 0, 64'h0, 0, 0, 0);
    rst_i = 1'b0;

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].in_valid, vecs[i].data, vecs[i].abort, vecs[i].out_ready);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_in_ready, vecs[i].exp_valid,
                  vecs[i].exp_idx, vecs[i].exp_onehot, vecs[i].exp_last,
                  vecs[i].exp_done, vecs[i].exp_cnt);
    end

    // Full 64-hot mask drains back to back; done one cycle after bit 63.
    applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    for (int i = 0; i < 64; i++) begin
      logic [63:0] oh;
      oh = 64'h1 << i;
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
      checkOutput($sformatf("full%0d", i), 0, 1, 6'(i), oh, (i == 63), 0, 7'(i));
    end
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
    checkOutput("full_done", 1, 0, 0, 64'h0, 0, 1, 64);

    // Abort after two beats, colliding with a handshake on the third.
    applyStimulus(1'b1, 64'h0F, 1'b0, 1'b1);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
    checkOutput("abort_b0", 0, 1, 0, 64'h1, 0, 0, 0);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
    checkOutput("abort_b1", 0, 1, 1, 64'h2, 0, 0, 1);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b1);
    checkOutput("abort_b2", 0, 1, 2, 64'h4, 0, 0, 2);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
    checkOutput("abort_idle", 1, 0, 0, 64'h0, 0, 0, 2);
    applyStimulus(1'b1, 64'h100, 1'b0, 1'b1);
    checkOutput("abort_nodone", 1, 0, 0, 64'h0, 0, 0, 2);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
    checkOutput("after_abort", 0, 1, 8, 64'h100, 1, 0, 0);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
    checkOutput("after_abort_done", 1, 0, 0, 64'h0, 0, 1, 1);

    // Reset mid-scan with a new mask offered: reset wins, nothing loads.
    applyStimulus(1'b1, 64'hFF00, 1'b0, 1'b1);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
    checkOutput("rst_b0", 0, 1, 8, 64'h100, 0, 0, 0);
    applyStimulus(1'b1, 64'hFF00, 1'b0, 1'b1);
    rst_i = 1'b1;
    checkOutput("rst_b1", 0, 1, 9, 64'h200, 0, 0, 1);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
    rst_i = 1'b0;
    checkOutput("rst_state", 1, 0, 0, 64'h0, 0, 0, 0);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
    checkOutput("rst_noload", 1, 0, 0, 64'h0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
